// File: rtl/uart_term_if.sv
// Handshake bundle for uart_term: host line side (term_*) and UART core pair side (uart_*).
interface uart_term_if;
  logic [7:0] term_tx_d;
  logic       term_tx_dv;
  logic       term_tx_dr;
  logic [7:0] term_rx_d;
  logic       term_rx_dv;
  logic       term_rx_dr;
  logic       term_rx_pok;
  logic [7:0] uart_rx_d;
  logic       uart_rx_dv;
  logic       parity_ok;
  logic [7:0] uart_tx_d;
  logic       uart_tx_dv;
  logic       uart_tx_dr;

  // Design side
  modport slave (
    input  term_tx_d, term_tx_dv, term_rx_dr,
    input  uart_rx_d, uart_rx_dv, parity_ok, uart_tx_dr,
    output term_tx_dr, term_rx_d, term_rx_dv, term_rx_pok,
    output uart_tx_d, uart_tx_dv
  );

  // Host sequencer / UART model side
  modport master (
    output term_tx_d, term_tx_dv, term_rx_dr,
    output uart_rx_d, uart_rx_dv, parity_ok, uart_tx_dr,
    input  term_tx_dr, term_rx_d, term_rx_dv, term_rx_pok,
    input  uart_tx_d, uart_tx_dv
  );
endinterface

// File: rtl/uart_term.sv
// Host end of an XON/XOFF console link: sends command lines, buffers console output,
// throttles the console with XOFF/XON and waits for the prompt after each CR.
module uart_term #(
  parameter logic [79:0] PROMPT     = "FDK>",
  parameter int          NR_BITS    = 8,
  parameter int          RX_FIFO    = 16,
  parameter int          XOFF_LEVEL = 12,
  parameter int          XON_LEVEL  = 4,
  parameter int          TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_term_if.slave  bus,
  output logic        prompt_seen,
  output logic        prompt_tmo,
  output logic        rx_overflow
);

  if (NR_BITS != 8) begin : g_bad_width
    $fatal(1, "uart_term: only NR_BITS=8 is supported");
  end

  // Prompt literal is right-justified; its length is the highest non-NUL byte.
  function automatic int plen(input logic [79:0] p);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++)
      if (p[8*i +: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  localparam int          PLEN  = plen(PROMPT);
  localparam logic [79:0] PMASK = (80'h1 << (8*PLEN)) - 80'h1;
  localparam int          AW    = (RX_FIFO > 1) ? $clog2(RX_FIFO) : 1;
  localparam int          CW    = $clog2(RX_FIFO + 1);
  localparam int          TW    = $clog2(TIMEOUT + 2);
  localparam logic [7:0]  XON   = 8'h11;
  localparam logic [7:0]  XOFF  = 8'h13;
  localparam logic [7:0]  CR    = 8'h0D;

  typedef enum logic {READY, WAIT} state_t;
  state_t state, state_n;

  logic [8:0]    mem [RX_FIFO];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          empty, full, rd, wr;
  logic          alive, xoff_sent, flow_pend, flow_xoff;
  logic          can_tx, send_flow, host_acc, xoff_req, xon_req;
  logic [79:0]   sh, sh_n;
  logic          match, seen_n, tmo_n;
  logic [TW-1:0] tcnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(RX_FIFO));
  assign rd    = bus.term_rx_dr & ~empty;
  // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
  assign wr    = bus.uart_rx_dv & (~full | rd);

  assign xoff_req = (cnt >= CW'(XOFF_LEVEL)) & ~xoff_sent;
  assign xon_req  = (cnt <= CW'(XON_LEVEL)) & xoff_sent;

  // One char per two cycles towards the TX core: never issue right after a dv.
  assign can_tx    = alive & bus.uart_tx_dr & ~bus.uart_tx_dv;
  assign send_flow = can_tx & flow_pend;
  assign bus.term_tx_dr = can_tx & ~flow_pend & (state == READY);
  assign host_acc  = bus.term_tx_dv & bus.term_tx_dr;

  // Prompt match looks at history including the byte arriving now (dropped bytes too).
  assign sh_n  = {sh[71:0], bus.uart_rx_d};
  assign match = bus.uart_rx_dv & ((sh_n & PMASK) == PROMPT);

  // Held low through reset and the first cycle after, so term_tx_dr reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;

  // FIFO storage: parity bit kept alongside the character.
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {bus.parity_ok, bus.uart_rx_d};

  // FIFO pointers, fill count, sticky overflow and registered read port.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0; rx_overflow <= 1'b0;
      bus.term_rx_d <= '0; bus.term_rx_pok <= 1'b0; bus.term_rx_dv <= 1'b0;
    end else begin
      if (wr) wp <= (wp == AW'(RX_FIFO-1)) ? '0 : wp + 1'b1;
      if (rd) begin
        rp <= (rp == AW'(RX_FIFO-1)) ? '0 : rp + 1'b1;
        {bus.term_rx_pok, bus.term_rx_d} <= mem[rp];
      end
      bus.term_rx_dv <= rd;
      if (wr & ~rd)      cnt <= cnt + 1'b1;
      else if (rd & ~wr) cnt <= cnt - 1'b1;
      if (bus.uart_rx_dv & full & ~rd) rx_overflow <= 1'b1;
    end

  // Flow-control slot: one pending char, a newer request overwrites an unsent one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xoff_sent <= 1'b0; flow_pend <= 1'b0; flow_xoff <= 1'b0;
    end else begin
      if (send_flow) flow_pend <= 1'b0;
      if (xoff_req) begin
        xoff_sent <= 1'b1; flow_pend <= 1'b1; flow_xoff <= 1'b1;
      end else if (xon_req) begin
        xoff_sent <= 1'b0; flow_pend <= 1'b1; flow_xoff <= 1'b0;
      end
    end

  // TX register: flow char wins over host char.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.uart_tx_d <= '0; bus.uart_tx_dv <= 1'b0;
    end else begin
      bus.uart_tx_dv <= send_flow | host_acc;
      if (send_flow)     bus.uart_tx_d <= flow_xoff ? XOFF : XON;
      else if (host_acc) bus.uart_tx_d <= bus.term_tx_d;
    end

  // Received-byte history for prompt detection.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              sh <= '0;
    else if (bus.uart_rx_dv) sh <= sh_n;

  // State register, wait timer and event pulses.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= READY; tcnt <= '0; prompt_seen <= 1'b0; prompt_tmo <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= (state == WAIT) ? tcnt + 1'b1 : '0;
      prompt_seen <= seen_n;
      prompt_tmo  <= tmo_n;
    end

  // Next state: CR opens a wait; prompt beats timeout when both land together.
  always_comb begin
    state_n = state;
    seen_n  = 1'b0;
    tmo_n   = 1'b0;
    case (state)
      READY: if (host_acc && bus.term_tx_d == CR) state_n = WAIT;
      WAIT: begin
        if (match) begin
          state_n = READY; seen_n = 1'b1;
        end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
          state_n = READY; tmo_n = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_term.sv
// Directed bench for uart_term with a queue scoreboard and a free-running monitor.
module tb_uart_term;
  logic clk = 1'b0;
  logic rst_n;
  logic prompt_seen, prompt_tmo, rx_overflow;

  uart_term_if bus();

  uart_term #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .prompt_seen(prompt_seen), .prompt_tmo(prompt_tmo), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rx[$];
  byte        exp_ev[$];

  logic [22:0] outs;
  assign outs = {bus.term_tx_dr, bus.term_rx_d, bus.term_rx_dv, bus.term_rx_pok,
                 prompt_seen, prompt_tmo, rx_overflow, bus.uart_tx_d, bus.uart_tx_dv};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event is popped against the scoreboard.
  logic       prev_dv;
  logic [7:0] m_tx;
  logic [8:0] m_rx;
  byte        m_ev;
  always @(negedge clk) begin
    if (!rst_n) prev_dv = 1'b0;
    else begin
      if (bus.uart_tx_dv) begin
        checks++;
        if (prev_dv) begin
          errors++; $display("FAIL tx_spacing actual=back-to-back expected=gap");
        end else if (exp_tx.size() == 0) begin
          errors++; $display("FAIL tx_unexpected actual=%h expected=none", bus.uart_tx_d);
        end else begin
          m_tx = exp_tx.pop_front();
          if (bus.uart_tx_d !== m_tx) begin
            errors++; $display("FAIL tx_char actual=%h expected=%h", bus.uart_tx_d, m_tx);
          end
        end
      end
      prev_dv = bus.uart_tx_dv;
      if (bus.term_rx_dv) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL rx_unexpected actual=%h expected=none", bus.term_rx_d);
        end else begin
          m_rx = exp_rx.pop_front();
          if ({bus.term_rx_pok, bus.term_rx_d} !== m_rx) begin
            errors++;
            $display("FAIL rx_char actual=%h expected=%h", {bus.term_rx_pok, bus.term_rx_d}, m_rx);
          end
        end
      end
      if (prompt_seen || prompt_tmo) begin
        checks++;
        if (exp_ev.size() == 0) begin
          errors++; $display("FAIL event_unexpected actual=%b%b expected=none", prompt_seen, prompt_tmo);
        end else begin
          m_ev = exp_ev.pop_front();
          if ((m_ev == "S") !== (prompt_seen && !prompt_tmo) || (m_ev == "T") !== (prompt_tmo && !prompt_seen)) begin
            errors++; $display("FAIL event_kind actual=%b%b expected=%s", prompt_seen, prompt_tmo, m_ev);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_host(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    bus.term_tx_d  = c;
    bus.term_tx_dv = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.term_tx_dr;
      @(posedge clk); #1;
    end
    bus.term_tx_dv = 1'b0;
    chk("host_accept", 32'(ok), 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic p);
    bus.uart_rx_d  = b;
    bus.parity_ok  = p;
    bus.uart_rx_dv = 1'b1;
    @(posedge clk); #1;
    bus.uart_rx_dv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] line[4];
    logic [7:0] pr[5];
    logic [7:0] c;
    logic       p;
    int         n;
    line = '{8'h76, 8'h65, 8'h72, 8'h0D};
    pr   = '{8'h0A, 8'h46, 8'h44, 8'h4B, 8'h3E};

    bus.term_tx_d = '0; bus.term_tx_dv = 1'b0; bus.term_rx_dr = 1'b0;
    bus.uart_rx_d = '0; bus.uart_rx_dv = 1'b0; bus.parity_ok = 1'b0;
    bus.uart_tx_dr = 1'b1;
    rst_n = 1'b0;

    // Reset: every output low, even with uart_tx_dr high.
    #12;
    chk("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // "ver",CR goes out in order, then host input blocks while waiting.
    foreach (line[i]) exp_tx.push_back(line[i]);
    foreach (line[i]) send_host(line[i]);
    @(negedge clk);
    chk("tx_dr_after_cr", 32'(bus.term_tx_dr), 32'd0);
    repeat (3) @(negedge clk);
    chk("tx_dr_in_wait", 32'(bus.term_tx_dr), 32'd0);
    @(posedge clk); #1;

    // Echo LF + prompt: prompt_seen, back to READY, five chars readable.
    exp_ev.push_back("S");
    foreach (pr[i]) exp_rx.push_back({1'b1, pr[i]});
    foreach (pr[i]) rx_byte(pr[i], 1'b1);
    @(negedge clk);
    chk("tx_dr_after_prompt", 32'(bus.term_tx_dr), 32'd1);
    @(posedge clk); #1;
    bus.term_rx_dr = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.term_rx_dr = 1'b0;

    // Lone CR with no reply: timeout 100 cycles after the accepting edge.
    exp_tx.push_back(8'h0D);
    exp_ev.push_back("T");
    send_host(8'h0D);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prompt_tmo) break;
      n++;
    end
    chk("tmo_cycle", 32'(n), 32'd100);
    @(negedge clk);
    chk("tx_dr_after_tmo", 32'(bus.term_tx_dr), 32'd1);
    @(posedge clk); #1;

    // 12 chars unread -> one XOFF; the prompt string in READY must not pulse.
    exp_tx.push_back(8'h13);
    for (int i = 0; i < 12; i++) begin
      c = (i >= 1 && i < 5) ? pr[i] : 8'h30 + 8'(i);
      p = (i != 6);
      exp_rx.push_back({p, c});
      rx_byte(c, p);
    end
    repeat (6) @(posedge clk);
    #1;
    exp_tx.push_back(8'h11);
    bus.term_rx_dr = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.term_rx_dr = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 17 chars into a 16-deep FIFO: last one dropped, overflow sticks.
    exp_tx.push_back(8'h13);
    for (int i = 0; i < 17; i++) begin
      c = 8'h40 + 8'(i);
      if (i < 16) exp_rx.push_back({1'b1, c});
      rx_byte(c, 1'b1);
      if (i == 15) begin
        @(negedge clk);
        chk("no_overflow_at_16", 32'(rx_overflow), 32'd0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("overflow_at_17", 32'(rx_overflow), 32'd1);
    @(posedge clk); #1;
    exp_tx.push_back(8'h11);
    bus.term_rx_dr = 1'b1;
    repeat (25) @(posedge clk);
    #1 bus.term_rx_dr = 1'b0;
    @(negedge clk);
    chk("overflow_sticky", 32'(rx_overflow), 32'd1);
    @(posedge clk); #1;

    // FIFO at 10, CR in flight, then reset mid-cycle: everything drops at once.
    for (int i = 0; i < 10; i++) rx_byte(8'h60 + 8'(i), 1'b1);
    send_host(8'h0D);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_wait", 32'(outs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.term_rx_dr = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.term_rx_dr = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.term_tx_dr), 32'd1);
    chk("overflow_cleared", 32'(rx_overflow), 32'd0);

    repeat (3) @(negedge clk);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    chk("event_queue_drained", 32'(exp_ev.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
